// File: rtl/wb_echo_emu.sv
// wb_echo_emu: Wishbone slave that stands in for an HC-SR04 ultrasonic sensor.
// It watches trig_i and, for each trigger held high long enough, drives an
// echo_o pulse whose width comes from the ECHO_LEN register.
// Optional feature: define ECHO_JITTER_EN to add 0..15 cycles of LFSR jitter
// to every echo width.
module wb_echo_emu #(
    parameter int TRIG_MIN_CYC = 500,
    parameter int LAUNCH_CYC   = 23000,
    parameter int MAX_ECHO_CYC = 1900000,
    parameter int CNT_W        = 24
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_dat_o,
    input  logic        wb_stb_i,
    input  logic        wb_cyc_i,
    input  logic        wb_we_i,
    input  logic [3:0]  wb_sel_i,
    output logic        wb_ack_o,
    input  logic        trig_i,
    output logic        echo_o,
    output logic        busy_o
);

    localparam int HCNT_W = $clog2(TRIG_MIN_CYC + 1);
    localparam int LCNT_W = $clog2(LAUNCH_CYC + 1);
    localparam logic [HCNT_W-1:0] TRIG_MIN    = HCNT_W'(TRIG_MIN_CYC);
    localparam logic [LCNT_W-1:0] LAUNCH_LAST = LCNT_W'(LAUNCH_CYC - 1);
    localparam logic [CNT_W-1:0]  MAX_ECHO    = CNT_W'(MAX_ECHO_CYC);

    typedef enum logic [1:0] {IDLE, TRIG_HI, LAUNCH, ECHO} state_t;

    state_t            state;
    logic [HCNT_W-1:0] hcnt;
    logic [LCNT_W-1:0] lcnt;
    logic [CNT_W-1:0]  ecnt;
    logic [CNT_W-1:0]  len;
    logic [CNT_W-1:0]  echo_len;
    logic [CNT_W-1:0]  base_len;
    logic [15:0]       count;
    logic              short_flag;
    logic              trig_p0, trig_s, trig_s_d;
    logic              trig_rise, trig_fall;
    logic              wb_acc, wb_wr, short_clr;
    logic [1:0]        sel;
    logic [31:0]       rd_data;

    // Bits the register map never looks at.
    logic unused_bits;
    assign unused_bits = &{1'b0, wb_sel_i, wb_adr_i[31:4], wb_adr_i[1:0], wb_dat_i[31:CNT_W]};

`ifdef ECHO_JITTER_EN
    logic [15:0] lfsr;
    logic [15:0] lfsr_next;

    // Fibonacci LFSR for x^16+x^14+x^13+x^11+1, shifting right.
    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return {v[0] ^ v[2] ^ v[3] ^ v[5], v[15:1]};
    endfunction

    // Add jitter to the echo length, clamping at the counter's full scale.
    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [3:0] b);
        logic [CNT_W:0] s;
        s = {1'b0, a} + (CNT_W+1)'(b);
        return s[CNT_W] ? '1 : s[CNT_W-1:0];
    endfunction

    assign lfsr_next = lfsr_step(lfsr);
`endif

    assign trig_rise = trig_s & ~trig_s_d;
    assign trig_fall = ~trig_s & trig_s_d;
    assign wb_acc    = wb_stb_i & wb_cyc_i & ~wb_ack_o;
    assign wb_wr     = wb_acc & wb_we_i;
    assign sel       = wb_adr_i[3:2];
    assign short_clr = wb_wr && (sel == 2'd1) && wb_dat_i[1];
    assign base_len  = (echo_len == '0) ? MAX_ECHO : echo_len;

    // Two-flop synchroniser for trig_i plus one delayed copy for edge detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            trig_p0  <= 1'b0;
            trig_s   <= 1'b0;
            trig_s_d <= 1'b0;
        end else begin
            trig_p0  <= trig_i;
            trig_s   <= trig_p0;
            trig_s_d <= trig_s;
        end
    end

    // Read-data mux for the four-word register map.
    always_comb begin
        rd_data = '0;
        case (sel)
            2'd0:    rd_data = 32'(echo_len);
            2'd1:    rd_data = {30'd0, short_flag, busy_o};
            2'd2:    rd_data = {16'd0, count};
            default: rd_data = '0;
        endcase
    end

    // Wishbone slave: single-cycle registered ack, ECHO_LEN writes, registered read data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wb_ack_o <= 1'b0;
            wb_dat_o <= '0;
            echo_len <= '0;
        end else begin
            wb_ack_o <= wb_acc;
            if (wb_acc && !wb_we_i)
                wb_dat_o <= rd_data;
            if (wb_wr && (sel == 2'd0))
                echo_len <= wb_dat_i[CNT_W-1:0];
        end
    end

    // Trigger qualification, launch delay and echo generation; SHORT clear loses to a same-cycle set.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            hcnt       <= '0;
            lcnt       <= '0;
            ecnt       <= '0;
            len        <= '0;
            echo_o     <= 1'b0;
            busy_o     <= 1'b0;
            short_flag <= 1'b0;
            count      <= '0;
`ifdef ECHO_JITTER_EN
            lfsr       <= 16'hACE1;
`endif
        end else begin
            if (short_clr)
                short_flag <= 1'b0;
            case (state)
                IDLE: begin
                    if (trig_rise) begin
                        hcnt  <= HCNT_W'(1);
                        state <= TRIG_HI;
                    end
                end
                TRIG_HI: begin
                    if (trig_fall) begin
                        if (hcnt >= TRIG_MIN) begin
`ifdef ECHO_JITTER_EN
                            len  <= sat_add(base_len, lfsr_next[3:0]);
                            lfsr <= lfsr_next;
`else
                            len  <= base_len;
`endif
                            lcnt   <= '0;
                            busy_o <= 1'b1;
                            state  <= LAUNCH;
                        end else begin
                            short_flag <= 1'b1;
                            state      <= IDLE;
                        end
                    end else if (hcnt != TRIG_MIN) begin
                        hcnt <= hcnt + HCNT_W'(1);
                    end
                end
                LAUNCH: begin
                    if (lcnt == LAUNCH_LAST) begin
                        echo_o <= 1'b1;
                        ecnt   <= CNT_W'(1);
                        state  <= ECHO;
                    end else begin
                        lcnt <= lcnt + LCNT_W'(1);
                    end
                end
                ECHO: begin
                    if (ecnt == len) begin
                        echo_o <= 1'b0;
                        busy_o <= 1'b0;
                        count  <= count + 16'd1;
                        state  <= IDLE;
                    end else begin
                        ecnt <= ecnt + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
